// File: rtl/mioc_flop_seq.sv
// Round-robin two-port sequencer for a bank of open-drain set/reset flops; one registered pulse per grant.
// Grant to ack: PULSE_CYC+GAP_CYC+2 cycles with MIOC_FLOP_VERIFY_EN defined, one fewer without; requests hold until ack.
module mioc_flop_seq #(
    parameter int NFLOP     = 4,
    parameter int IDXW      = $clog2(NFLOP),
    parameter int PULSE_CYC = 3,
    parameter int GAP_CYC   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_req,
    input  logic             a_op,
    input  logic [IDXW-1:0]  a_idx,
    output logic             a_ack,
    input  logic             b_req,
    input  logic             b_op,
    input  logic [IDXW-1:0]  b_idx,
    output logic             b_ack,
    output logic             resp_err,
    output logic [NFLOP-1:0] flop_set,
    output logic [NFLOP-1:0] flop_clr,
    output logic [NFLOP-1:0] flop_clr_n,
    input  logic [NFLOP-1:0] flop_q,
    output logic [NFLOP-1:0] q_sync,
    output logic             busy,
    output logic             err_sticky,
    input  logic             err_clr
);
    localparam int CMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {S_IDLE, S_PULSE, S_GAP, S_VERIFY, S_ACK} state_t;

    state_t            r_state, w_state_nx;
    logic [CW-1:0]     r_cnt, w_cnt_nx;
    logic              r_op, r_who, r_last_b;
    logic [IDXW-1:0]   r_idx;
    logic [NFLOP-1:0]  r_set, r_clr, r_clr_n, r_sync1, r_sync2;
    logic              r_a_ack, r_b_ack, r_busy;

    logic              w_ld, w_grant_b, w_op_nx, w_who_nx;
    logic [IDXW-1:0]   w_idx_nx;
    logic [NFLOP-1:0]  w_hot;

    // Tie goes to whichever requester was not granted last.
    assign w_grant_b = b_req & (~a_req | ~r_last_b);

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_ld       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_state_nx = S_PULSE;
                    w_cnt_nx   = CW'(PULSE_CYC);
                    w_ld       = 1'b1;
                end
            end
            S_PULSE: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = CW'(GAP_CYC);
                end else begin
                    w_cnt_nx   = r_cnt - CW'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == CW'(1)) begin
`ifdef MIOC_FLOP_VERIFY_EN
                    w_state_nx = S_VERIFY;
`else
                    w_state_nx = S_ACK;
`endif
                end else begin
                    w_cnt_nx   = r_cnt - CW'(1);
                end
            end
            S_VERIFY: w_state_nx = S_ACK;
            S_ACK:    w_state_nx = S_IDLE;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    assign w_op_nx  = w_ld ? (w_grant_b ? b_op  : a_op)  : r_op;
    assign w_idx_nx = w_ld ? (w_grant_b ? b_idx : a_idx) : r_idx;
    assign w_who_nx = w_ld ? w_grant_b : r_who;

    // Out-of-range index matches no bit, so no pulse is driven.
    always_comb begin
        w_hot = '0;
        for (int i = 0; i < NFLOP; i++) begin
            if (w_idx_nx == IDXW'(i)) w_hot[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= 1'b0;
            r_idx    <= '0;
            r_who    <= 1'b0;
            r_last_b <= 1'b1;
            r_set    <= '0;
            r_clr    <= '0;
            r_clr_n  <= '1;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_busy   <= 1'b0;
            r_sync1  <= '0;
            r_sync2  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_op    <= w_op_nx;
            r_idx   <= w_idx_nx;
            r_who   <= w_who_nx;
            if (r_state == S_ACK) r_last_b <= r_who;
            r_set   <= (w_state_nx == S_PULSE &&  w_op_nx) ? w_hot : '0;
            r_clr   <= (w_state_nx == S_PULSE && !w_op_nx) ? w_hot : '0;
            r_clr_n <= (w_state_nx == S_PULSE && !w_op_nx) ? ~w_hot : '1;
            r_a_ack <= (w_state_nx == S_ACK) && !w_who_nx;
            r_b_ack <= (w_state_nx == S_ACK) &&  w_who_nx;
            r_busy  <= (w_state_nx != S_IDLE);
            r_sync1 <= flop_q;
            r_sync2 <= r_sync1;
        end
    end

`ifdef MIOC_FLOP_VERIFY_EN
    logic r_resp_err, r_err_sticky, w_hit, w_qbit, w_mis;

    always_comb begin
        w_hit  = 1'b0;
        w_qbit = 1'b0;
        for (int i = 0; i < NFLOP; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_hit  = 1'b1;
                w_qbit = r_sync2[i];
            end
        end
        w_mis = !w_hit || (w_qbit != r_op);
    end

    // A mismatch in the same cycle as err_clr keeps the sticky flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_err   <= 1'b0;
            r_err_sticky <= 1'b0;
        end else begin
            r_resp_err <= (r_state == S_VERIFY) && w_mis;
            if (r_state == S_VERIFY && w_mis) r_err_sticky <= 1'b1;
            else if (err_clr)                 r_err_sticky <= 1'b0;
        end
    end

    assign resp_err   = r_resp_err;
    assign err_sticky = r_err_sticky;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = err_clr;
    assign resp_err   = 1'b0;
    assign err_sticky = 1'b0;
`endif

    assign a_ack      = r_a_ack;
    assign b_ack      = r_b_ack;
    assign flop_set   = r_set;
    assign flop_clr   = r_clr;
    assign flop_clr_n = r_clr_n;
    assign q_sync     = r_sync2;
    assign busy       = r_busy;
endmodule

// File: tb/tb_mioc_flop_seq.sv
// Scoreboarded bench for mioc_flop_seq: directed requests push expected acks, a negedge monitor checks them.
module tb_mioc_flop_seq;
`ifdef MIOC_FLOP_VERIFY_EN
    localparam int LAT = 7;
    localparam bit VON = 1'b1;
`else
    localparam int LAT = 6;
    localparam bit VON = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       a_req = 0, a_op = 0, b_req = 0, b_op = 0, err_clr = 0;
    logic [2:0] a_idx = 0, b_idx = 0;
    logic       a_ack, b_ack, resp_err, busy, err_sticky;
    logic [3:0] flop_set, flop_clr, flop_clr_n, flop_q, q_sync;
    logic [3:0] mq = 4'b0000;
    logic       stuck = 1'b0;

    mioc_flop_seq #(.NFLOP(4), .IDXW(3), .PULSE_CYC(3), .GAP_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_op(a_op), .a_idx(a_idx), .a_ack(a_ack),
        .b_req(b_req), .b_op(b_op), .b_idx(b_idx), .b_ack(b_ack),
        .resp_err(resp_err), .flop_set(flop_set), .flop_clr(flop_clr),
        .flop_clr_n(flop_clr_n), .flop_q(flop_q), .q_sync(q_sync),
        .busy(busy), .err_sticky(err_sticky), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // Flop bank model: set/clear pulses act on the rising edge; stuck forces all q high.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (flop_set[i])      mq[i] <= 1'b1;
            else if (flop_clr[i]) mq[i] <= 1'b0;
        end
    end
    assign flop_q = stuck ? 4'b1111 : mq;

    typedef struct {
        bit         who;
        bit         err;
        bit         sticky;
        logic [3:0] s;
        logic [3:0] c;
        int         pc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input int got, input int want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: accumulates pulse activity per transaction and checks it when an ack appears.
    logic [3:0] acc_s, acc_c;
    int         pc, start, cyc = 0;
    bit         in_txn = 0, bad_ovl, bad_cn;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            in_txn = 0;
        end else begin
            if (busy && !in_txn) begin
                in_txn = 1; start = cyc; acc_s = 0; acc_c = 0; pc = 0; bad_ovl = 0; bad_cn = 0;
            end
            if (in_txn) begin
                acc_s |= flop_set;
                acc_c |= flop_clr;
                if ((flop_set | flop_clr) != 4'b0000) pc++;
                if ((flop_set & flop_clr) != 4'b0000) bad_ovl = 1;
                if (flop_clr_n !== ~flop_clr) bad_cn = 1;
            end
            if (a_ack || b_ack) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_exclusive", int'(a_ack & b_ack), 0);
                    chk("ack_who", int'(b_ack), int'(e.who));
                    chk("resp_err", int'(resp_err), int'(e.err));
                    chk("err_sticky_at_ack", int'(err_sticky), int'(e.sticky));
                    chk("set_mask", int'(acc_s), int'(e.s));
                    chk("clr_mask", int'(acc_c), int'(e.c));
                    chk("pulse_cycles", pc, e.pc);
                    chk("ack_latency", in_txn ? cyc - start + 1 : -1, LAT);
                    chk("no_set_clr_overlap", int'(bad_ovl), 0);
                    chk("clr_n_complement", int'(bad_cn), 0);
                end
                in_txn = 0;
            end
        end
    end

    task automatic wait_ack(output time t);
        bit seen = 0;
        t = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (a_ack || b_ack) begin seen = 1; t = $time; end
        end
        if (!seen) chk("ack_timeout", 0, 1);
    endtask

    task automatic push(input bit who, input bit err, input bit st,
                        input logic [3:0] s, input logic [3:0] c, input int pcy);
        exp_t e;
        e.who = who; e.err = err; e.sticky = st; e.s = s; e.c = c; e.pc = pcy;
        exp_q.push_back(e);
    endtask

    task automatic run_a(input bit op, input logic [2:0] idx);
        time t;
        @(posedge clk) #1;
        a_op = op; a_idx = idx; a_req = 1;
        wait_ack(t);
        @(posedge clk) #1 a_req = 0;
    endtask

    initial begin
        time t0, t1, t2;
        #12;
        chk("rst_flop_set", int'(flop_set), 0);
        chk("rst_flop_clr", int'(flop_clr), 0);
        chk("rst_flop_clr_n", int'(flop_clr_n), 15);
        chk("rst_acks", int'({a_ack, b_ack}), 0);
        chk("rst_resp_err", int'(resp_err), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_q_sync", int'(q_sync), 0);
        chk("rst_err_sticky", int'(err_sticky), 0);
        @(posedge clk) #1 rst_n = 1;
        repeat (2) @(posedge clk);

        // Set flop 2 from A, flop model follows the pulse.
        push(0, 0, 0, 4'b0100, 4'b0000, 3);
        run_a(1'b1, 3'd2);

        // Clear flop 1 from B with the flops stuck high.
        stuck = 1;
        push(1, VON, VON, 4'b0000, 4'b0010, 3);
        @(posedge clk) #1;
        b_op = 0; b_idx = 3'd1; b_req = 1;
        wait_ack(t0);
        @(posedge clk) #1 b_req = 0; err_clr = 1;
        @(posedge clk) #1 err_clr = 0;
        chk("err_clr_clears", int'(err_sticky), 0);
        stuck = 0;
        repeat (4) @(posedge clk);

        // Both requesters held: last grant was B, so A, B, A.
        push(0, 0, 0, 4'b0001, 4'b0000, 3);
        push(1, 0, 0, 4'b0000, 4'b1000, 3);
        push(0, 0, 0, 4'b0001, 4'b0000, 3);
        @(posedge clk) #1;
        a_op = 1; a_idx = 3'd0; a_req = 1;
        b_op = 0; b_idx = 3'd3; b_req = 1;
        wait_ack(t0);
        wait_ack(t1);
        wait_ack(t2);
        @(posedge clk) #1 a_req = 0; b_req = 0;
        chk("ack_period_1", int'((t1 - t0) / 10), LAT + 1);
        chk("ack_period_2", int'((t2 - t1) / 10), LAT + 1);
        repeat (3) @(posedge clk);

        // Reset in the second pulse cycle truncates the pulse; no ack follows.
        @(posedge clk) #1;
        a_op = 1; a_idx = 3'd3; a_req = 1;
        for (int k = 0; k < 10 && !busy; k++) @(negedge clk);
        @(posedge clk) #2;
        chk("pulse_before_reset", int'(flop_set), 8);
        rst_n = 0;
        #1;
        chk("pulse_cut_by_reset", int'(flop_set), 0);
        chk("busy_in_reset", int'(busy), 0);
        a_req = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        repeat (3) @(negedge clk);
        chk("busy_after_release", int'(busy), 0);

        // Clean restart: clear flop 2.
        push(0, 0, 0, 4'b0000, 4'b0100, 3);
        run_a(1'b0, 3'd2);

        // Out-of-range index: no pulse anywhere.
        push(0, VON, VON, 4'b0000, 4'b0000, 0);
        run_a(1'b1, 3'd5);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mioc_flop_seq.md
# mioc_flop_seq

Pulse sequencer and two-port arbiter for a bank of NFLOP open-drain MIOC set/reset flops. Two requesters (A, B) ask to set or clear one flop; the block grants one request at a time, round-robin, and drives a fixed-width set or reset pulse onto that flop. It then holds a recovery gap and optionally reads the flop back through a synchronizer. All pulse outputs are registered and glitch-free, so the flop bank never sees set and reset together.

## Interface
- NFLOP, 4: number of flops driven; must be ≥2.
- IDXW, $clog2(NFLOP): flop index width.
- PULSE_CYC, 3: set/reset pulse width in clk cycles; must be ≥1.
- GAP_CYC, 2: low-time after each pulse before the next action; must be ≥2.
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset; release synchronous to clk.
- a_req  in  1  requester A request, level, held until a_ack.
- a_op  in  1  1 = set flop, 0 = clear flop.
- a_idx  in  IDXW  target flop index.
- a_ack  out  1  one-cycle completion strobe to A.
- b_req / b_op / b_idx / b_ack: identical to A.
- resp_err  out  1  valid only while a_ack or b_ack is high; 1 = readback mismatch.
- flop_set  out  NFLOP  set pulse per flop (drives in4).
- flop_clr  out  NFLOP  posedge reset pulse per flop (drives in1).
- flop_clr_n  out  NFLOP  registered complement of flop_clr (drives in3).
- flop_q  in  NFLOP  asynchronous q outputs from the flops.
- q_sync  out  NFLOP  flop_q after a 2-stage synchronizer.
- busy  out  1  high in every state except IDLE.
- err_sticky  out  1  set on any mismatch; cleared by err_clr.
- err_clr  in  1  synchronous clear of err_sticky.

## Operation
- FSM states are IDLE, PULSE, GAP, VERIFY, ACK.
- IDLE:
  - If any req is high, grant, latch op/idx/requester, load the counter with PULSE_CYC, and go to PULSE.
  - If both reqs are high, grant the one not granted last. The last-grant register resets to B, so A wins the first tie.
- PULSE:
  - Exactly one bit of flop_set (op=1) or flop_clr (op=0) is high at the latched idx; flop_clr_n is the same bit low.
  - Count down. At zero, load GAP_CYC and go to GAP.
- GAP: all pulses are low. Count down, then go to VERIFY (macro on) or ACK (macro off).
- VERIFY, one cycle:
  - resp_err_next = (q_sync[idx] != op).
  - If resp_err_next is set, err_sticky is set.
- ACK, one cycle:
  - The granted requester's ack is high and resp_err is valid. Update the last-grant register, then go to IDLE.
- Requests and latching:
  - req/op/idx are sampled only in IDLE. Changes during other states are ignored.
  - A req withdrawn before grant is dropped silently.
  - A req still high in the IDLE cycle after its ack counts as a new request.
- Out-of-range idx (≥NFLOP): no pulse is driven, resp_err=1 at ack, and err_sticky is set.
- If err_clr and a mismatch occur in the same cycle, set wins.

## Timing
- Reset values (asynchronous, while rst_n=0):
  - state=IDLE, flop_set=0, flop_clr=0, flop_clr_n=all 1s.
  - a_ack=b_ack=0, resp_err=0, busy=0, q_sync=0, err_sticky=0, last-grant=B.
- Reset mid-pulse truncates the pulse immediately.
- Let T be the grant edge:
  - Pulse is high on cycles T+1 … T+PULSE_CYC.
  - Gap runs T+PULSE_CYC+1 … T+PULSE_CYC+GAP_CYC.
  - With the macro, VERIFY is at T+PULSE_CYC+GAP_CYC+1 and ack at +2.
  - Without the macro, ack is at T+PULSE_CYC+GAP_CYC+1.
- Defaults, macro on: ack 7 cycles after grant. Back-to-back grant to ack period is 8 cycles (ack, then the IDLE grant cycle).
- busy rises the cycle after grant and falls in the IDLE cycle after ack.
- flop_clr and flop_clr_n are both registered from the same next-state, never a combinational invert.
- Set and clear are never high in the same cycle on any bit.

## Configuration
- MIOC_FLOP_VERIFY_EN:
  - Defined: VERIFY state, resp_err and err_sticky are active as above.
  - Undefined: VERIFY is removed, GAP goes directly to ACK, resp_err=0, and err_sticky is tied 0. Out-of-range idx still suppresses the pulse.
  - The q_sync synchronizer is present in both builds.

## Test plan
- Reset, then a_req=1, a_op=1, a_idx=2, with the flop model following the pulse:
  - flop_set=4'b0100 for 3 cycles, then 2 low cycles.
  - a_ack 7 cycles after grant, resp_err=0.
- a_req and b_req asserted together, both holding:
  - Grants alternate A, B, A.
  - Acks are 8 cycles apart.
  - No cycle has any flop_set&flop_clr bit set.
- b_req=1, b_op=0, b_idx=1 with the flop model stuck at q=1 (macro on):
  - flop_clr=4'b0010 for 3 cycles and flop_clr_n=4'b1101.
  - b_ack with resp_err=1 and err_sticky=1.
  - err_clr then clears err_sticky.
- rst_n pulled low in the 2nd PULSE cycle:
  - flop_set goes to 0 asynchronously and no ack is issued.
  - After release, busy=0 and a new request starts cleanly.
- a_idx=5 with NFLOP=4: no pulse on any bit, and a_ack with resp_err=1.
- Macro undefined, same as the first scenario: ack 6 cycles after grant, resp_err=0.
